// File: rtl/iob_counter_pkg.sv
// Shared counter definitions: overflow-handling mode encodings.
package iob_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/iob_reg_are_n.sv
// Register with async active-low reset, clock enable, sync reset and load enable.
module iob_reg_are_n #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q <= RST_VAL;
    end else if (cke_i) begin
      if (rst_i) begin
        data_q <= RST_VAL;
      end else if (en_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_counter_mod_ud.sv
// Up/down counter over [0, max_i] with variable step, load, wrap or saturate
// handling, a one-cycle event pulse and a sticky overflow flag.
module iob_counter_mod_ud
  import iob_counter_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RST_VAL  = '0,
  parameter int                SATURATE = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              evt_o,
  output logic              ovf_o
);

  localparam mode_e           MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
  localparam logic [DATA_W:0] ONE  = (DATA_W+1)'(1);

  logic [DATA_W-1:0] data_q, data_d, s;
  logic [DATA_W:0]   up_sum;
  logic              evt_q, evt_d, ovf_q, ovf_d;

  // Sums carry one extra bit so max_i+1 and data+s never truncate.
  always_comb begin
    s      = (step_i < max_i) ? step_i : max_i;
    up_sum = {1'b0, data_q} + {1'b0, s};
    data_d = data_q;
    evt_d  = 1'b0;
    if (ld_i) begin
      if (ld_val_i > max_i) begin
        data_d = max_i;
        evt_d  = 1'b1;
      end else begin
        data_d = ld_val_i;
      end
    end else if (en_i) begin
      if (data_q > max_i) begin
        data_d = max_i;
        evt_d  = 1'b1;
      end else if (dir_i) begin
        if (up_sum > {1'b0, max_i}) begin
          evt_d  = 1'b1;
          data_d = (MODE == MODE_SAT) ? max_i
                                      : DATA_W'(up_sum - {1'b0, max_i} - ONE);
        end else begin
          data_d = DATA_W'(up_sum);
        end
      end else begin
        if (data_q < s) begin
          evt_d  = 1'b1;
          data_d = (MODE == MODE_SAT) ? '0
                 : DATA_W'({1'b0, data_q} + {1'b0, max_i} + ONE - {1'b0, s});
        end else begin
          data_d = data_q - s;
        end
      end
    end
    // A new event wins over a simultaneous clear.
    ovf_d = evt_d | (ovf_q & ~clr_i);
  end

  iob_reg_are_n #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_data_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .en_i     (ld_i | en_i),
    .data_i   (data_d),
    .data_o   (data_q)
  );

  iob_reg_are_n #(.DATA_W(1), .RST_VAL(1'b0)) u_evt_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .en_i     (1'b1),
    .data_i   (evt_d),
    .data_o   (evt_q)
  );

  iob_reg_are_n #(.DATA_W(1), .RST_VAL(1'b0)) u_ovf_reg (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .en_i     (1'b1),
    .data_i   (ovf_d),
    .data_o   (ovf_q)
  );

  assign data_o = data_q;
  assign evt_o  = evt_q;
  assign ovf_o  = ovf_q;

endmodule

// File: doc/iob_counter_mod_ud.md
IOB_COUNTER_MOD_UD -- requirements
Module: iob_counter_mod_ud

Interface
REQ-001 Parameter DATA_W, default 32: counter, load-value and limit width in bits (>=2).
REQ-002 Parameter RST_VAL, default 0: value of data_o after async or sync reset.
REQ-003 Parameter SATURATE, default 0: 0 means modulo wrap, 1 means clamp at 0/max_i.
REQ-004 Port clk_i, input, 1: sole clock, rising edge.
REQ-005 Port arst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 Port cke_i, input, 1: clock enable; when low, all state holds and every other input is ignored.
REQ-007 Port rst_i, input, 1: synchronous reset, active-high.
REQ-008 Port en_i, input, 1: count enable.
REQ-009 Port dir_i, input, 1: 1 counts up, 0 counts down.
REQ-010 Port step_i, input, DATA_W: increment magnitude.
REQ-011 Port max_i, input, DATA_W: inclusive upper limit; counting range is [0, max_i].
REQ-012 Port ld_i, input, 1: synchronous load.
REQ-013 Port ld_val_i, input, DATA_W: load value.
REQ-014 Port clr_i, input, 1: clears the sticky flag.
REQ-015 Port data_o, output, DATA_W: counter value, registered.
REQ-016 Port evt_o, output, 1: registered one-cycle pulse for a wrap/clamp event.
REQ-017 Port ovf_o, output, 1: registered sticky event flag.

Function
REQ-018 All updates SHALL occur on the rising edge of clk_i, and only when cke_i=1.
REQ-019 Priority SHALL be rst_i > ld_i > en_i; with none active, data_o holds and evt_o=0.
REQ-020 rst_i SHALL force data_o=RST_VAL, evt_o=0 and ovf_o=0.
REQ-021 ld_i SHALL set data_o=min(ld_val_i, max_i); evt_o=1 only if clamped; ovf_o is set on that event.
REQ-022 The effective step SHALL be s=min(step_i, max_i); all sums are computed in DATA_W+1 bits with no truncation.
REQ-023 Up, wrap mode: if data_o+s > max_i, next = data_o+s-(max_i+1) with evt_o=1; otherwise next = data_o+s.
REQ-024 Down, wrap mode: if data_o < s, next = data_o+(max_i+1)-s with evt_o=1; otherwise next = data_o-s.
REQ-025 Up, saturate mode: if data_o+s > max_i, next = max_i with evt_o=1; this recurs on every enabled cycle at the limit when s>0.
REQ-026 Down, saturate mode: if data_o < s, next = 0 with evt_o=1.
REQ-027 If data_o > max_i on an enabled cycle (max_i lowered at runtime), next SHALL be max_i with evt_o=1, regardless of dir_i.
REQ-028 s=0 SHALL hold data_o and never raise evt_o.
REQ-029 evt_o SHALL be high exactly in the cycle following the event edge, and low otherwise.
REQ-030 ovf_o SHALL set with evt_o and hold until clr_i or a reset.
REQ-031 If clr_i and an event coincide on the same edge, set SHALL win.
REQ-032 data_o update latency SHALL be 1 cycle; there is no combinational path from any input to any output.

Reset
REQ-033 arst_n_i low SHALL immediately force data_o=RST_VAL, evt_o=0 and ovf_o=0, independent of clk_i and cke_i.
REQ-034 Assertion of arst_n_i mid-count SHALL abort the count; the first enabled edge after release resumes counting from RST_VAL.

Structure
REQ-035 Mode encodings (MODE_WRAP=0, MODE_SAT=1) SHALL live in the shared counter package iob_counter_pkg; no other shared typedefs are needed.
REQ-036 Next-state arithmetic SHALL be a single combinational block.
REQ-037 Storage SHALL be three instances of sub-module iob_reg_are_n (async active-low reset, cke, sync rst, en) for data, evt and ovf.

Verification (DATA_W=8, max_i=9, step_i=3)
REQ-038 Wrap up: ld 8, en, dir=1 -> data_o=1, evt_o=1 for one cycle, ovf_o=1.
REQ-039 Wrap down: data_o=1, en, dir=0 -> data_o=8, evt_o=1; then 5, 2, 9 with evt_o high only on the 2->9 step.
REQ-040 Saturate: SATURATE=1, data_o=8, en, dir=1 for 2 cycles -> 9, 9 with evt_o=1 both cycles; dir=0 from 1 -> 0, evt_o=1.
REQ-041 Load clamp and priority: ld_val_i=200 -> data_o=9, evt_o=1; rst_i with ld_i and en_i -> RST_VAL; clr_i with a simultaneous event -> ovf_o=1.
REQ-042 Runtime limit: data_o=9, max_i changed to 4, en -> data_o=4, evt_o=1; step_i=20 -> effective step 4.
REQ-043 cke_i=0 with all controls active -> no change; arst_n_i low mid-count -> RST_VAL immediately, then resume.
